// File: rtl/midi_voice_assign_if.sv
// Byte-stream input and note/voice output bundle of the MIDI voice allocator.
// The master side feeds MIDI bytes; the slave side is the allocator itself.
interface midi_voice_assign_if #(
    parameter int VOICES  = 8,
    parameter int V_WIDTH = 3
);
    logic               byte_ready;
    logic [7:0]         midi_byte;
    logic [3:0]         midi_ch;
    logic               busy;
    logic               note_on;
    logic [V_WIDTH-1:0] cur_key_adr;
    logic [7:0]         cur_key_val;
    logic [7:0]         cur_vel_on;
    logic [VOICES-1:0]  keys_on;

    modport master (
        output byte_ready, midi_byte, midi_ch,
        input  busy, note_on, cur_key_adr, cur_key_val, cur_vel_on, keys_on
    );

    modport slave (
        input  byte_ready, midi_byte, midi_ch,
        output busy, note_on, cur_key_adr, cur_key_val, cur_vel_on, keys_on
    );
endinterface

// File: rtl/midi_voice_assign.sv
// Single-channel MIDI note parser and voice allocator. Outputs are registered
// and change together in one commit cycle so a slower domain can sample them.
module midi_voice_assign #(
    parameter int VOICES  = 8,
    parameter int V_WIDTH = 3
) (
    input  logic               sys_clk,
    input  logic               reset_reg_N,
    midi_voice_assign_if.slave bus
);
    localparam logic [0:0] P_WAIT_KEY = 1'b0;
    localparam logic [0:0] P_WAIT_VEL = 1'b1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCAN   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [0:0]         pstate_reg;
    logic               rs_valid_reg;
    logic               rs_on_reg;
    logic [6:0]         key_reg;
    logic [6:0]         vel_reg;
    logic               ev_reg;
    logic               ev_on_reg;

    logic [1:0]         fsm_reg;
    logic [V_WIDTH-1:0] idx_reg;
    logic               match_found_reg;
    logic [V_WIDTH-1:0] match_idx_reg;
    logic               free_found_reg;
    logic [V_WIDTH-1:0] free_idx_reg;
    logic [V_WIDTH-1:0] steal_ptr_reg;
    logic [6:0]         key_tab [VOICES];

    logic               busy_reg;
    logic               note_on_reg;
    logic [V_WIDTH-1:0] cur_key_adr_reg;
    logic [7:0]         cur_key_val_reg;
    logic [7:0]         cur_vel_on_reg;
    logic [VOICES-1:0]  keys_on_reg;

    logic [VOICES-1:0]  key_hit;
    logic [V_WIDTH-1:0] sel_idx;
    logic               accept;

    generate
        for (genvar gi = 0; gi < VOICES; gi++) begin : g_hit
            assign key_hit[gi] = keys_on_reg[gi] && (key_tab[gi] == key_reg);
        end
    endgenerate

    always_comb begin
        sel_idx = steal_ptr_reg;
        if (match_found_reg)
            sel_idx = match_idx_reg;
        else if (free_found_reg)
            sel_idx = free_idx_reg;
    end

    // A pending event counts as busy so the parser cannot overwrite key/vel.
    assign accept = bus.byte_ready && !busy_reg && !ev_reg;

    always_ff @(posedge sys_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            pstate_reg      <= P_WAIT_KEY;
            rs_valid_reg    <= 1'b0;
            rs_on_reg       <= 1'b0;
            key_reg         <= '0;
            vel_reg         <= '0;
            ev_reg          <= 1'b0;
            ev_on_reg       <= 1'b0;
            fsm_reg         <= S_IDLE;
            idx_reg         <= '0;
            match_found_reg <= 1'b0;
            match_idx_reg   <= '0;
            free_found_reg  <= 1'b0;
            free_idx_reg    <= '0;
            steal_ptr_reg   <= '0;
            for (int i = 0; i < VOICES; i++)
                key_tab[i] <= '0;
            busy_reg        <= 1'b0;
            note_on_reg     <= 1'b0;
            cur_key_adr_reg <= '0;
            cur_key_val_reg <= '0;
            cur_vel_on_reg  <= '0;
            keys_on_reg     <= '0;
        end else begin
            if (accept) begin
                if (bus.midi_byte[7]) begin
                    // Real-time bytes (F8..FF) leave the parser untouched.
                    if (bus.midi_byte < 8'hF8) begin
                        pstate_reg <= P_WAIT_KEY;
                        if (bus.midi_byte[3:0] == bus.midi_ch && bus.midi_byte[7:4] == 4'h9) begin
                            rs_valid_reg <= 1'b1;
                            rs_on_reg    <= 1'b1;
                        end else if (bus.midi_byte[3:0] == bus.midi_ch && bus.midi_byte[7:4] == 4'h8) begin
                            rs_valid_reg <= 1'b1;
                            rs_on_reg    <= 1'b0;
                        end else begin
                            rs_valid_reg <= 1'b0;
                        end
                    end
                end else if (rs_valid_reg) begin
                    if (pstate_reg == P_WAIT_KEY) begin
                        key_reg    <= bus.midi_byte[6:0];
                        pstate_reg <= P_WAIT_VEL;
                    end else begin
                        vel_reg    <= bus.midi_byte[6:0];
                        ev_reg     <= 1'b1;
                        ev_on_reg  <= rs_on_reg && (bus.midi_byte[6:0] != 7'd0);
                        pstate_reg <= P_WAIT_KEY;
                    end
                end
            end

            case (fsm_reg)
                S_IDLE: begin
                    if (ev_reg) begin
                        ev_reg          <= 1'b0;
                        fsm_reg         <= S_SCAN;
                        busy_reg        <= 1'b1;
                        idx_reg         <= '0;
                        match_found_reg <= 1'b0;
                        free_found_reg  <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (key_hit[idx_reg] && !match_found_reg) begin
                        match_found_reg <= 1'b1;
                        match_idx_reg   <= idx_reg;
                    end
                    if (!keys_on_reg[idx_reg] && !free_found_reg) begin
                        free_found_reg <= 1'b1;
                        free_idx_reg   <= idx_reg;
                    end
                    if (idx_reg == V_WIDTH'(VOICES - 1))
                        fsm_reg <= S_COMMIT;
                    else
                        idx_reg <= idx_reg + 1'b1;
                end
                S_COMMIT: begin
                    fsm_reg  <= S_IDLE;
                    busy_reg <= 1'b0;
                    if (ev_on_reg) begin
                        if (!match_found_reg && !free_found_reg)
                            steal_ptr_reg <= steal_ptr_reg + 1'b1;
                        key_tab[sel_idx]     <= key_reg;
                        keys_on_reg[sel_idx] <= 1'b1;
                        cur_key_adr_reg      <= sel_idx;
                        cur_key_val_reg      <= {1'b0, key_reg};
                        cur_vel_on_reg       <= {1'b0, vel_reg};
                        note_on_reg          <= 1'b1;
                    end else if (match_found_reg) begin
                        keys_on_reg[match_idx_reg] <= 1'b0;
                        cur_key_adr_reg            <= match_idx_reg;
                        cur_key_val_reg            <= {1'b0, key_reg};
                        note_on_reg                <= 1'b0;
                    end
                end
                default: begin
                    fsm_reg  <= S_IDLE;
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_reg;
    assign bus.note_on     = note_on_reg;
    assign bus.cur_key_adr = cur_key_adr_reg;
    assign bus.cur_key_val = cur_key_val_reg;
    assign bus.cur_vel_on  = cur_vel_on_reg;
    assign bus.keys_on     = keys_on_reg;
endmodule

// File: tb/tb_midi_voice_assign.sv
// Directed bench for midi_voice_assign: a table of byte groups with expected
// outputs, plus hand sequences for commit timing and reset during a scan.
module tb_midi_voice_assign;
    localparam int VOICES = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    typedef struct {
        int              nb;
        logic [3:0][7:0] b;
        logic [7:0]      keys;
        logic [7:0]      adr;
        logic [7:0]      kv;
        logic [7:0]      vel;
        logic [7:0]      on;
    } vec_t;

    vec_t vecs [21];

    midi_voice_assign_if #(.VOICES(8), .V_WIDTH(3)) bus ();

    midi_voice_assign #(.VOICES(8), .V_WIDTH(3)) dut (
        .sys_clk     (clk),
        .reset_reg_N (rst_n),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(int nb, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                                logic [7:0] b3, logic [7:0] keys, logic [7:0] adr,
                                logic [7:0] kv, logic [7:0] vel, logic [7:0] on);
        vec_t v;
        v.nb   = nb;
        v.b[0] = b0;
        v.b[1] = b1;
        v.b[2] = b2;
        v.b[3] = b3;
        v.keys = keys;
        v.adr  = adr;
        v.kv   = kv;
        v.vel  = vel;
        v.on   = on;
        return v;
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp_v);
        end
    endtask

    task automatic send_byte(logic [7:0] b);
        @(negedge clk);
        bus.byte_ready = 1'b1;
        bus.midi_byte  = b;
        @(negedge clk);
        bus.byte_ready = 1'b0;
        bus.midi_byte  = 8'h00;
    endtask

    task automatic check_outputs(string tag, logic [7:0] keys, logic [7:0] adr,
                                 logic [7:0] kv, logic [7:0] vel, logic [7:0] on);
        check({tag, ".keys_on"},     bus.keys_on, keys);
        check({tag, ".cur_key_adr"}, {5'd0, bus.cur_key_adr}, adr);
        check({tag, ".cur_key_val"}, bus.cur_key_val, kv);
        check({tag, ".cur_vel_on"},  bus.cur_vel_on, vel);
        check({tag, ".note_on"},     {7'd0, bus.note_on}, on);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        bus.byte_ready = 1'b0;
        bus.midi_byte  = 8'h00;
        bus.midi_ch    = 4'h0;

        //           nb  b0     b1     b2     b3     keys   adr    kv     vel    on
        vecs[0]  = mk(3, 8'h90, 8'h3C, 8'h64, 8'h00, 8'h01, 8'd0, 8'h3C, 8'h64, 8'd1);
        vecs[1]  = mk(2, 8'h3E, 8'h50, 8'h00, 8'h00, 8'h03, 8'd1, 8'h3E, 8'h50, 8'd1);
        vecs[2]  = mk(2, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h02, 8'd0, 8'h3C, 8'h50, 8'd0);
        vecs[3]  = mk(2, 8'h3E, 8'h7F, 8'h00, 8'h00, 8'h02, 8'd1, 8'h3E, 8'h7F, 8'd1);
        vecs[4]  = mk(3, 8'h91, 8'h40, 8'h50, 8'h00, 8'h02, 8'd1, 8'h3E, 8'h7F, 8'd1);
        vecs[5]  = mk(3, 8'hB0, 8'h07, 8'h64, 8'h00, 8'h02, 8'd1, 8'h3E, 8'h7F, 8'd1);
        vecs[6]  = mk(3, 8'h80, 8'h40, 8'h00, 8'h00, 8'h02, 8'd1, 8'h3E, 8'h7F, 8'd1);
        vecs[7]  = mk(2, 8'h3E, 8'h00, 8'h00, 8'h00, 8'h00, 8'd1, 8'h3E, 8'h7F, 8'd0);
        vecs[8]  = mk(4, 8'h90, 8'h30, 8'hF8, 8'h40, 8'h01, 8'd0, 8'h30, 8'h40, 8'd1);
        vecs[9]  = mk(2, 8'h31, 8'h41, 8'h00, 8'h00, 8'h03, 8'd1, 8'h31, 8'h41, 8'd1);
        vecs[10] = mk(2, 8'h32, 8'h42, 8'h00, 8'h00, 8'h07, 8'd2, 8'h32, 8'h42, 8'd1);
        vecs[11] = mk(2, 8'h33, 8'h43, 8'h00, 8'h00, 8'h0F, 8'd3, 8'h33, 8'h43, 8'd1);
        vecs[12] = mk(2, 8'h34, 8'h44, 8'h00, 8'h00, 8'h1F, 8'd4, 8'h34, 8'h44, 8'd1);
        vecs[13] = mk(2, 8'h35, 8'h45, 8'h00, 8'h00, 8'h3F, 8'd5, 8'h35, 8'h45, 8'd1);
        vecs[14] = mk(2, 8'h36, 8'h46, 8'h00, 8'h00, 8'h7F, 8'd6, 8'h36, 8'h46, 8'd1);
        vecs[15] = mk(2, 8'h37, 8'h47, 8'h00, 8'h00, 8'hFF, 8'd7, 8'h37, 8'h47, 8'd1);
        vecs[16] = mk(2, 8'h38, 8'h48, 8'h00, 8'h00, 8'hFF, 8'd0, 8'h38, 8'h48, 8'd1);
        vecs[17] = mk(2, 8'h39, 8'h49, 8'h00, 8'h00, 8'hFF, 8'd1, 8'h39, 8'h49, 8'd1);
        vecs[18] = mk(3, 8'h80, 8'h38, 8'h00, 8'h00, 8'hFE, 8'd0, 8'h38, 8'h49, 8'd0);
        vecs[19] = mk(3, 8'h90, 8'h30, 8'h50, 8'h00, 8'hFF, 8'd0, 8'h30, 8'h50, 8'd1);
        vecs[20] = mk(2, 8'h3A, 8'h51, 8'h00, 8'h00, 8'hFF, 8'd2, 8'h3A, 8'h51, 8'd1);

        repeat (3) @(negedge clk);
        check_outputs("reset", 8'h00, 8'd0, 8'h00, 8'h00, 8'd0);
        check("reset.busy", {7'd0, bus.busy}, 8'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            for (int k = 0; k < vecs[i].nb; k++)
                send_byte(vecs[i].b[k]);
            repeat (VOICES + 4) @(posedge clk);
            #1;
            $display("vec %0d: keys_on=%02h adr=%0d key=%02h vel=%02h note_on=%0d",
                     i, bus.keys_on, bus.cur_key_adr, bus.cur_key_val, bus.cur_vel_on, bus.note_on);
            check_outputs($sformatf("vec%0d", i), vecs[i].keys, vecs[i].adr,
                          vecs[i].kv, vecs[i].vel, vecs[i].on);
            check($sformatf("vec%0d.busy", i), {7'd0, bus.busy}, 8'd0);
        end

        // Commit timing: busy rises one edge after T, outputs land VOICES+2 edges after T.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h90);
        send_byte(8'h3C);
        check("timing.key_only", bus.keys_on, 8'h00);
        send_byte(8'h64);
        check("timing.busy_T", {7'd0, bus.busy}, 8'd0);
        @(posedge clk);
        #1;
        check("timing.busy_T1", {7'd0, bus.busy}, 8'd1);
        repeat (VOICES) @(posedge clk);
        #1;
        check("timing.busy_T9", {7'd0, bus.busy}, 8'd1);
        check("timing.keys_T9", bus.keys_on, 8'h00);
        @(posedge clk);
        #1;
        $display("timing: busy=%0d keys_on=%02h at T+%0d", bus.busy, bus.keys_on, VOICES + 2);
        check("timing.busy_T10", {7'd0, bus.busy}, 8'd0);
        check_outputs("timing", 8'h01, 8'd0, 8'h3C, 8'h64, 8'd1);

        // Reset in the middle of a scan clears everything at once.
        send_byte(8'h3E);
        send_byte(8'h50);
        repeat (4) @(posedge clk);
        #1;
        check("midscan.busy", {7'd0, bus.busy}, 8'd1);
        rst_n = 1'b0;
        #1;
        $display("midscan reset: keys_on=%02h busy=%0d", bus.keys_on, bus.busy);
        check_outputs("midscan", 8'h00, 8'd0, 8'h00, 8'h00, 8'd0);
        check("midscan.busy_rst", {7'd0, bus.busy}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h90);
        send_byte(8'h40);
        send_byte(8'h60);
        repeat (VOICES + 4) @(posedge clk);
        #1;
        $display("after reset: keys_on=%02h adr=%0d key=%02h vel=%02h",
                 bus.keys_on, bus.cur_key_adr, bus.cur_key_val, bus.cur_vel_on);
        check_outputs("post_reset", 8'h01, 8'd0, 8'h40, 8'h60, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/midi_voice_assign.md
# midi_voice_assign

Parses a MIDI byte stream for one channel and allocates note-on/note-off events to `VOICES` voice slots. It produces the note/key/velocity/voice-occupancy bus that the OSC_CLK-domain synchronizer samples and latches at the voice-scan frame boundary, so it is the writer side of that interface. Runs entirely in the `sys_clk` domain. All outputs are registered and only change in a single commit cycle.

## Interface
- `VOICES`, 8: number of voice slots; power of two, ≥2.
- `V_WIDTH`, 3: log2(`VOICES`).
- `sys_clk`  in  1  system clock.
- `reset_reg_N`  in  1  asynchronous, active-low reset.
- `byte_ready`  in  1  one-cycle strobe; `midi_byte` is valid on this cycle.
- `midi_byte`  in  8  received MIDI byte.
- `midi_ch`  in  4  channel to respond to; static during operation.
- `busy`  out  1  high while an allocation is in progress.
- `note_on`  out  1  level: 1 after a note-on commit, 0 after a note-off commit.
- `cur_key_adr`  out  V_WIDTH  voice index touched by the last commit.
- `cur_key_val`  out  8  {1'b0, key} of the last commit.
- `cur_vel_on`  out  8  {1'b0, velocity} of the last note-on.
- `keys_on`  out  VOICES  per-voice occupancy bitmap.

## Operation
- Reset: all outputs 0, key table (VOICES×7 bits) 0, `steal_ptr` 0, running status cleared, parser in WAIT_KEY, FSM in IDLE.
- Parser. It acts only on `byte_ready`:
  - 0xF8–0xFF (real-time): ignored; parser state untouched.
  - 0x9n with n==`midi_ch`: running status = ON, go to WAIT_KEY.
  - 0x8n with n==`midi_ch`: running status = OFF, go to WAIT_KEY.
  - Any other status 0x80–0xF7: running status cleared; data bytes are ignored until the next matching status.
  - Data byte with running status valid: in WAIT_KEY, latch key[6:0] and go to WAIT_VEL. In WAIT_VEL, latch vel[6:0], raise an event, and return to WAIT_KEY, keeping running status.
  - Event type: ON with vel≠0 is a note-on. ON with vel=0, or OFF with any velocity, is a note-off.
- FSM: IDLE → SCAN (on event) → COMMIT → IDLE.
- SCAN lasts `VOICES` cycles, with idx = 0..VOICES-1. Each cycle it records:
  - first_match: the first idx with keys_on[idx]=1 and key_tab[idx]==key.
  - first_free: the first idx with keys_on[idx]=0.
- COMMIT for a note-on. Voice selection: first_match if found, else first_free if found, else `steal_ptr`; in the steal case `steal_ptr` increments mod VOICES. Then:
  - write key_tab[sel]=key and set keys_on[sel];
  - set `cur_key_adr`=sel, `cur_key_val`={0,key}, `cur_vel_on`={0,vel}, `note_on`=1.
- COMMIT for a note-off:
  - If a match is found: clear keys_on[match], set `cur_key_adr`=match, `cur_key_val`={0,key}, `note_on`=0. `cur_vel_on` is unchanged.
  - If no match: no output changes.
- Bytes arriving with `byte_ready` while `busy`=1 are dropped; the parser does not advance. Upstream must not do this. At MIDI rate (one byte per 320 µs) it cannot occur.

## Timing
- Let edge T be the edge that samples the velocity-byte strobe.
- `busy` goes high after edge T and stays high through SCAN and COMMIT, for `VOICES`+1 cycles. It falls on the edge that ends COMMIT.
- Outputs update on that same edge, `VOICES`+2 edges after T, and all change together. Outputs are then held stable until the next commit, as required by the 2-FF sampling downstream.
- A status or key byte alone produces no output change.
- Back-to-back events are accepted as soon as `busy`=0.
- Reset asserted mid-SCAN or mid-COMMIT: immediate return to the reset state, with no partial table write.
- `steal_ptr` wraps from VOICES-1 to 0.

## Test plan
- Reset, then bytes 0x90,0x3C,0x64 with `midi_ch`=0 → after 10 edges: keys_on=0x01, cur_key_adr=0, cur_key_val=0x3C, cur_vel_on=0x64, note_on=1.
- Running status: continue with 0x3E,0x50 → keys_on=0x03, cur_key_adr=1. Then 0x3C,0x00 → keys_on=0x02, cur_key_adr=0, note_on=0, cur_vel_on stays 0x50.
- Retrigger: send note 0x3E again with vel 0x7F → keys_on unchanged, cur_key_adr=1, cur_vel_on=0x7F.
- Stealing: fill 8 voices with keys 0x30–0x37, then send 0x38 and 0x39 → cur_key_adr=0 then 1, key_tab[0]=0x38, keys_on stays 0xFF.
- Filtering:
  - 0x91 key/vel with midi_ch=0 → no change.
  - 0xF8 inserted between key and vel → event still fires.
  - 0xB0 followed by data bytes → ignored.
  - 0x80,0x40,0x00 for a key that is not on → no output change.
- Assert `reset_reg_N`=0 mid-SCAN → all outputs 0 immediately. The next valid note-on then lands in voice 0.
